// File: rtl/pio_poll_ctrl_if.sv
// Bus bundle for pio_poll_ctrl.
//   pio_*  : downstream side, to the 4-bit input PIO slave (address out, readdata in)
//   avs_*  : upstream Avalon-MM slave seen by the CPU
//   irq    : level interrupt to the CPU
// The slave modport is the controller's view; master is the bench/system view.
interface pio_poll_ctrl_if;
  logic [1:0]  pio_address;
  logic [31:0] pio_readdata;
  logic [1:0]  avs_address;
  logic        avs_chipselect;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;

  modport slave (
    output pio_address,
    input  pio_readdata,
    input  avs_address, avs_chipselect, avs_read, avs_write, avs_writedata,
    output avs_readdata,
    output irq
  );

  modport master (
    input  pio_address,
    output pio_readdata,
    output avs_address, avs_chipselect, avs_read, avs_write, avs_writedata,
    input  avs_readdata,
    input  irq
  );
endinterface

// File: rtl/pio_poll_ctrl.sv
// pio_poll_ctrl: polls a PIO input slave at a programmable interval,
// debounces the sampled bits, latches edges and raises a maskable irq.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high
//   bus   - pio_poll_ctrl_if.slave: pio_address/pio_readdata toward the PIO,
//           avs_* CPU register slave (1-cycle registered read), irq.
// Registers: 0 STATE (ro), 1 EDGE (w1c), 2 MASK (rw), 3 INTERVAL (rw).
module pio_poll_ctrl #(
  parameter int WIDTH        = 4,
  parameter int POLL_DEFAULT = 1000,
  parameter int DEB_SAMPLES  = 3,
  parameter int CNT_W        = 32
) (
  input logic           clk,
  input logic           reset,
  pio_poll_ctrl_if.slave bus
);

  localparam int DCW = (DEB_SAMPLES > 1) ? $clog2(DEB_SAMPLES) : 1;
  localparam logic [DCW-1:0] DEB_MAX = DCW'(DEB_SAMPLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, CAPT} state_t;

  // Effective period: intervals below 2 collapse to back-to-back polling.
  function automatic logic [CNT_W-1:0] eff(input logic [CNT_W-1:0] v);
    return (v < CNT_W'(2)) ? CNT_W'(2) : v;
  endfunction

  state_t           st, st_nxt;
  logic [CNT_W-1:0] tmr, tmr_nxt;
  logic [CNT_W-1:0] interval_q;
  logic [WIDTH-1:0] stat_q, edge_q, mask_q, prev_q;
  logic [DCW-1:0]   cnt_q, cnt_nxt;
  logic [WIDTH-1:0] raw, new_edge;
  logic             commit;
  logic             wr, rd, wr_int;
  logic [31:0]      rmux;
  logic             unused_pio_hi;

  assign raw    = bus.pio_readdata[WIDTH-1:0];
  assign unused_pio_hi = ^bus.pio_readdata[31:WIDTH];
  assign wr     = bus.avs_chipselect & bus.avs_write;
  assign rd     = bus.avs_chipselect & bus.avs_read;
  assign wr_int = wr && (bus.avs_address == 2'd3);

  // The timer holds "cycles left minus one" so that a REQ lands exactly
  // P cycles after it is loaded; it keeps running through REQ/CAPT so the
  // period is measured REQ-to-REQ.
  always_comb begin
    st_nxt          = st;
    tmr_nxt         = (tmr != '0) ? tmr - CNT_W'(1) : tmr;
    bus.pio_address = 2'b11;
    case (st)
      IDLE: begin
        if (wr_int) begin
          // Restart: the write cycle counts as the first of the new period.
          tmr_nxt = eff(CNT_W'(bus.avs_writedata)) - CNT_W'(2);
        end else if (tmr == '0) begin
          st_nxt  = REQ;
          tmr_nxt = eff(interval_q) - CNT_W'(1);
        end
      end
      REQ: begin
        bus.pio_address = 2'b00;
        st_nxt          = CAPT;
      end
      CAPT: begin
        if (tmr == '0) begin
          st_nxt  = REQ;
          tmr_nxt = eff(interval_q) - CNT_W'(1);
        end else begin
          st_nxt  = IDLE;
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  // Debounce: count consecutive identical samples, saturating at DEB_MAX.
  always_comb begin
    if (raw != prev_q)        cnt_nxt = '0;
    else if (cnt_q == DEB_MAX) cnt_nxt = cnt_q;
    else                       cnt_nxt = cnt_q + DCW'(1);
    commit   = (st == CAPT) && (cnt_nxt == DEB_MAX);
    new_edge = commit ? (stat_q ^ raw) : '0;
  end

  always_comb begin
    case (bus.avs_address)
      2'd0:    rmux = 32'(stat_q);
      2'd1:    rmux = 32'(edge_q);
      2'd2:    rmux = 32'(mask_q);
      default: rmux = 32'(interval_q);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st               <= IDLE;
      tmr              <= eff(CNT_W'(POLL_DEFAULT)) - CNT_W'(1);
      interval_q       <= CNT_W'(POLL_DEFAULT);
      stat_q           <= '0;
      edge_q           <= '0;
      mask_q           <= '0;
      prev_q           <= '0;
      cnt_q            <= '0;
      bus.avs_readdata <= '0;
      bus.irq          <= 1'b0;
    end else begin
      st  <= st_nxt;
      tmr <= tmr_nxt;
      if (st == CAPT) begin
        prev_q <= raw;
        cnt_q  <= cnt_nxt;
        if (commit) stat_q <= raw;
      end
      // New edges win over a simultaneous write-1-to-clear.
      edge_q <= (edge_q & ~((wr && bus.avs_address == 2'd1) ?
                            bus.avs_writedata[WIDTH-1:0] : '0)) | new_edge;
      if (wr && bus.avs_address == 2'd2) mask_q <= bus.avs_writedata[WIDTH-1:0];
      if (wr_int) interval_q <= CNT_W'(bus.avs_writedata);
      // rmux reflects pre-write register values, so read+write returns old data.
      bus.avs_readdata <= rd ? rmux : 32'd0;
      bus.irq          <= |(edge_q & mask_q);
    end
  end

endmodule

// File: tb/tb_pio_poll_ctrl.sv
module tb_pio_poll_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pio_poll_ctrl_if bus();

  pio_poll_ctrl #(
    .WIDTH(4), .POLL_DEFAULT(1000), .DEB_SAMPLES(3), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end 1ns after a rising edge.
  task automatic avs_wr(input logic [1:0] a, input logic [31:0] d);
    bus.avs_address = a; bus.avs_writedata = d;
    bus.avs_chipselect = 1'b1; bus.avs_write = 1'b1;
    @(posedge clk); #1;
    bus.avs_chipselect = 1'b0; bus.avs_write = 1'b0;
  endtask

  task automatic avs_rd(input logic [1:0] a, output logic [31:0] d);
    bus.avs_address = a;
    bus.avs_chipselect = 1'b1; bus.avs_read = 1'b1;
    @(posedge clk); #1;
    bus.avs_chipselect = 1'b0; bus.avs_read = 1'b0;
    d = bus.avs_readdata;
  endtask

  task automatic avs_rw(input logic [1:0] a, input logic [31:0] wd, output logic [31:0] d);
    bus.avs_address = a; bus.avs_writedata = wd;
    bus.avs_chipselect = 1'b1; bus.avs_read = 1'b1; bus.avs_write = 1'b1;
    @(posedge clk); #1;
    bus.avs_chipselect = 1'b0; bus.avs_read = 1'b0; bus.avs_write = 1'b0;
    d = bus.avs_readdata;
  endtask

  // Returns in the REQ cycle (bounded).
  task automatic wait_req();
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (bus.pio_address != 2'b00 && n < 3000);
    chk("req_seen", 32'(bus.pio_address), 32'd0);
  endtask

  // One full poll: returns the cycle after CAPT, sample committed.
  task automatic poll();
    wait_req();
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int first, second, nreq;
    reset = 1'b1;
    bus.pio_readdata = 32'd0;
    bus.avs_address = 2'd0; bus.avs_chipselect = 1'b0;
    bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.avs_writedata = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Cycle 0: reset values, then REQ at cycles 1000 and 2000.
    chk("rst_pio_addr", 32'(bus.pio_address), 32'd3);
    chk("rst_rdata", bus.avs_readdata, 32'd0);
    chk("rst_irq", 32'(bus.irq), 32'd0);
    first = -1; second = -1; nreq = 0;
    for (int k = 1; k <= 2000; k++) begin
      @(posedge clk); #1;
      if (bus.pio_address == 2'b00) begin
        nreq++;
        if (first < 0) first = k; else if (second < 0) second = k;
      end
    end
    chk("req1_cycle", 32'(first), 32'd1000);
    chk("req2_cycle", 32'(second), 32'd2000);
    chk("req_count", 32'(nreq), 32'd2);
    chk("irq_idle", 32'(bus.irq), 32'd0);
    avs_rd(2'd0, d); chk("rst_state", d, 32'd0);
    avs_rd(2'd1, d); chk("rst_edge", d, 32'd0);
    avs_rd(2'd2, d); chk("rst_mask", d, 32'd0);
    avs_rd(2'd3, d); chk("rst_interval", d, 32'd1000);

    // Debounce: hold 1010 (upper PIO bits garbage) for three polls.
    avs_wr(2'd3, 32'd5);
    avs_rd(2'd3, d); chk("interval_5", d, 32'd5);
    bus.pio_readdata = 32'hFFFF_FFFA;
    poll(); poll();
    avs_rd(2'd0, d); chk("state_2polls", d, 32'd0);
    poll();
    avs_rd(2'd0, d); chk("state_3polls", d, 32'hA);
    avs_rd(2'd1, d); chk("edge_after_A", d, 32'hA);

    // Mask / irq / w1c.
    avs_wr(2'd2, 32'h2);
    @(posedge clk); #1;
    chk("irq_masked_on", 32'(bus.irq), 32'd1);
    avs_rw(2'd2, 32'hC, d); chk("rw_old_mask", d, 32'h2);
    avs_rd(2'd2, d); chk("rw_new_mask", d, 32'hC);
    avs_wr(2'd2, 32'h2);
    avs_wr(2'd1, 32'h2);
    @(posedge clk); #1;
    chk("irq_cleared", 32'(bus.irq), 32'd0);
    avs_rd(2'd1, d); chk("edge_w1c", d, 32'h8);

    // Clear colliding with a new edge on bit0 (A -> B).
    bus.pio_readdata = 32'h0000_000B;
    poll(); poll();
    wait_req();
    @(posedge clk); #1;          // CAPT cycle
    avs_wr(2'd1, 32'hF);
    avs_rd(2'd1, d); chk("edge_collide", d, 32'h1);
    avs_rd(2'd0, d); chk("state_B", d, 32'hB);

    // Bounce: alternating samples never settle.
    avs_wr(2'd1, 32'h1);
    for (int i = 0; i < 6; i++) begin
      bus.pio_readdata = (i % 2 == 0) ? 32'h1 : 32'h0;
      poll();
    end
    avs_rd(2'd0, d); chk("bounce_state", d, 32'hB);
    avs_rd(2'd1, d); chk("bounce_edge", d, 32'h0);
    chk("bounce_irq", 32'(bus.irq), 32'd0);

    // INTERVAL=0: REQ every 2 cycles, first one 2 cycles after the write.
    poll();
    bus.pio_readdata = 32'h5;
    avs_wr(2'd3, 32'd0);
    chk("i0_w1", 32'(bus.pio_address), 32'd3);
    for (int j = 2; j <= 7; j++) begin
      @(posedge clk); #1;
      chk($sformatf("i0_w%0d", j), 32'(bus.pio_address), (j % 2 == 0) ? 32'd0 : 32'd3);
    end

    // Reset during CAPT with a changed input.
    wait_req();
    @(posedge clk); #1;          // CAPT cycle
    bus.pio_readdata = 32'h6;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_capt_addr", 32'(bus.pio_address), 32'd3);
    avs_rd(2'd0, d); chk("rst_capt_state", d, 32'd0);
    avs_rd(2'd1, d); chk("rst_capt_edge", d, 32'd0);
    avs_rd(2'd3, d); chk("rst_capt_interval", d, 32'd1000);
    chk("rst_capt_pio", 32'(bus.pio_address), 32'd3);
    chk("rst_capt_irq", 32'(bus.irq), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
